// File: rtl/fhe_op_sequencer.sv
// Command scheduler in front of the FHE cpu core: queues operations in a small FIFO and
// issues them one at a time, handshaking on cpu_done, with a hung-op watchdog.
package fhe_types_pkg;
   typedef enum logic [2:0] {
      NO_OP     = 3'd0,
      CT_CT_ADD = 3'd1,
      CT_PT_ADD = 3'd2,
      CT_CT_MUL = 3'd3,
      CT_PT_MUL = 3'd4
   } op_mode_e;

   typedef struct packed {
      op_mode_e   mode;
      logic [3:0] src0;
      logic [3:0] src1;
      logic [3:0] src2;
      logic [3:0] src3;
      logic [3:0] dst0;
      logic [3:0] dst1;
   } operation;
endpackage

module fhe_op_sequencer
   import fhe_types_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 500,
   parameter int CNT_W          = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  operation                      in_op,
   input  logic                          flush,
   input  logic                          clear_err,
   output operation                      cpu_op,
   input  logic                          cpu_done,
   output logic                          busy,
   output logic                          op_done,
   output logic                          err_timeout,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]              ops_issued,
   output logic [CNT_W-1:0]              ops_completed
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SETTLE, S_ERR} state_e;

   state_e           state, state_d;
   operation         mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [TW-1:0]    timer, timer_d;
   operation         cpu_op_d;
   logic             op_done_d, err_d;
   logic [CNT_W-1:0] issued_d, completed_d;
   logic             push, pop;

   // NO_OP commands are acknowledged but never stored; flush also blocks the push.
   assign in_ready = (fifo_count != CW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready && (in_op.mode != NO_OP) && !flush;
   assign busy     = (state != S_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_op;
   end

   always_comb begin
      state_d     = state;
      cpu_op_d    = cpu_op;
      op_done_d   = 1'b0;
      err_d       = err_timeout;
      timer_d     = timer;
      pop         = 1'b0;
      issued_d    = ops_issued;
      completed_d = ops_completed;
      case (state)
         S_IDLE: begin
            if ((fifo_count != '0) && !flush) begin
               pop      = 1'b1;
               cpu_op_d = mem[rd_ptr];
               issued_d = ops_issued + CNT_W'(1);
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cpu_op_d      = '0;
            cpu_op_d.mode = NO_OP;
            timer_d       = '0;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            if (cpu_done) begin
               completed_d = ops_completed + CNT_W'(1);
               op_done_d   = 1'b1;
               state_d     = S_SETTLE;
            end else if (timer == TIMER_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         S_SETTLE: state_d = S_IDLE;
         S_ERR: begin
            // A late cpu_done here is deliberately ignored.
            if (clear_err) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         cpu_op        <= '0;
         cpu_op.mode   <= NO_OP;
         op_done       <= 1'b0;
         err_timeout   <= 1'b0;
         timer         <= '0;
         ops_issued    <= '0;
         ops_completed <= '0;
      end else begin
         state         <= state_d;
         cpu_op        <= cpu_op_d;
         op_done       <= op_done_d;
         err_timeout   <= err_d;
         timer         <= timer_d;
         ops_issued    <= issued_d;
         ops_completed <= completed_d;
         if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fhe_op_sequencer.sv
// Scoreboard bench for fhe_op_sequencer: expected issues are queued at enqueue time and
// matched as the sequencer drives them; a small cpu responder answers with cpu_done.
module tb_fhe_op_sequencer;
   import fhe_types_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 500;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          reset, in_valid, flush, clear_err, cpu_done;
   operation      in_op, cpu_op;
   logic          in_ready, busy, op_done, err_timeout;
   logic [2:0]    fifo_count;
   logic [CW-1:0] ops_issued, ops_completed;

   fhe_op_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .flush(flush), .clear_err(clear_err), .cpu_op(cpu_op), .cpu_done(cpu_done),
      .busy(busy), .op_done(op_done), .err_timeout(err_timeout), .fifo_count(fifo_count),
      .ops_issued(ops_issued), .ops_completed(ops_completed)
   );

   always #5 clk = ~clk;

   int       checks = 0, errors = 0;
   int       cyc = 0;
   operation sb[$];
   bit       prev_issue = 0, have_done = 0, auto_done = 0, pend = 0, man_done = 0, man_ok = 0;
   int       done_delay = 3, pend_cnt = 0, done_cyc = 0, exp_od_cyc = -100;
   int       last_issue_cyc = 0, n_issued = 0;
   int       exp_issued = 0, exp_completed = 0;

   function automatic operation mk(op_mode_e m, int a, int b, int c, int d, int e, int f);
      operation o;
      o.mode = m; o.src0 = 4'(a); o.src1 = 4'(b); o.src2 = 4'(c);
      o.src3 = 4'(d); o.dst0 = 4'(e); o.dst1 = 4'(f);
      return o;
   endfunction

   // One clock: drive the cpu side for the coming cycle, then monitor outputs at +1.
   task automatic tick();
      operation exp;
      @(posedge clk); #1; cyc++;
      cpu_done = 1'b0;
      if (man_done) begin
         cpu_done = 1'b1; man_done = 0;
         if (man_ok) begin
            exp_od_cyc = cyc + 1; exp_completed++; done_cyc = cyc; have_done = 1;
         end
      end else if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            cpu_done = 1'b1; pend = 0;
            exp_od_cyc = cyc + 1; exp_completed++; done_cyc = cyc; have_done = 1;
         end
      end
      if (cpu_op.mode != NO_OP) begin
         checks++;
         if (sb.size() == 0) begin
            errors++; $display("FAIL issue_unexpected: got %h, required nothing", cpu_op);
         end else begin
            exp = sb.pop_front();
            if (cpu_op !== exp) begin
               errors++; $display("FAIL issue_order: got %h, required %h", cpu_op, exp);
            end else exp_issued++;
         end
         checks++;
         if (prev_issue) begin
            errors++; $display("FAIL issue_width: op still driven at cycle %0d, required 1 cycle", cyc);
         end
         if (have_done) begin
            checks++;
            if (cyc - done_cyc < 3) begin
               errors++; $display("FAIL issue_gap: %0d cycles after done, required >=3", cyc - done_cyc);
            end
         end
         n_issued++; last_issue_cyc = cyc;
         if (auto_done) begin pend = 1; pend_cnt = done_delay; end
      end
      prev_issue = (cpu_op.mode != NO_OP);
      checks++;
      if (op_done !== (cyc == exp_od_cyc)) begin
         errors++; $display("FAIL op_done: got %b at cycle %0d, required %b", op_done, cyc, cyc == exp_od_cyc);
      end
   endtask

   task automatic push(operation op, bit exp_accept);
      in_valid = 1'b1; in_op = op;
      if (exp_accept && op.mode != NO_OP) sb.push_back(op);
      tick();
      in_valid = 1'b0; in_op = '0;
   endtask

   task automatic manual_done(bit ok);
      man_done = 1; man_ok = ok;
      tick();
   endtask

   task automatic wait_issue(int bound);
      int n0 = n_issued;
      for (int i = 0; i < bound && n_issued == n0; i++) tick();
      checks++;
      if (n_issued == n0) begin
         errors++; $display("FAIL wait_issue: no issue within %0d cycles, required one", bound);
      end
   endtask

   task automatic wait_idle(int bound);
      int i = 0;
      while (i < bound && (sb.size() != 0 || busy || pend)) begin tick(); i++; end
      checks++;
      if (i >= bound) begin
         errors++; $display("FAIL wait_idle: %0d ops pending after %0d cycles, required 0", sb.size(), bound);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 0; flush = 0; clear_err = 0; cpu_done = 0; in_op = '0;
      tick(); tick();
      checks += 8;
      if (cpu_op !== '0)          begin errors++; $display("FAIL rst_cpu_op: got %h, required 0", cpu_op); end
      if (in_ready !== 1'b1)      begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      if (op_done !== 1'b0)       begin errors++; $display("FAIL rst_op_done: got %b, required 0", op_done); end
      if (err_timeout !== 1'b0)   begin errors++; $display("FAIL rst_err: got %b, required 0", err_timeout); end
      if (fifo_count !== 3'd0)    begin errors++; $display("FAIL rst_count: got %0d, required 0", fifo_count); end
      if (ops_issued !== '0)      begin errors++; $display("FAIL rst_issued: got %0d, required 0", ops_issued); end
      if (ops_completed !== '0)   begin errors++; $display("FAIL rst_completed: got %0d, required 0", ops_completed); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int p;
      auto_done = 1; done_delay = 3;
      push(mk(CT_CT_ADD, 0, 1, 2, 3, 5, 6), 1);
      p = cyc;
      checks++;
      if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", fifo_count); end
      tick();
      checks++;
      if (n_issued != 1 || last_issue_cyc != p + 1) begin
         errors++; $display("FAIL single_latency: issue at cycle %0d, required %0d", last_issue_cyc, p + 1);
      end
      wait_idle(50);
      checks += 2;
      if (ops_issued !== CW'(exp_issued) || exp_issued != 1) begin
         errors++; $display("FAIL single_issued: got %0d, required 1", ops_issued);
      end
      if (ops_completed !== CW'(exp_completed) || exp_completed != 1) begin
         errors++; $display("FAIL single_completed: got %0d, required 1", ops_completed);
      end
   endtask

   task automatic test_back_to_back();
      auto_done = 0;
      push(mk(CT_CT_MUL, 1, 2, 3, 4, 7, 8), 1);
      wait_issue(10);
      push(mk(CT_PT_ADD, 2, 3, 4, 5, 9, 10), 1);
      push(mk(CT_CT_ADD, 3, 4, 5, 6, 11, 12), 1);
      push(mk(CT_PT_MUL, 4, 5, 6, 7, 13, 14), 1);
      push(mk(CT_CT_MUL, 5, 6, 7, 8, 15, 0), 1);
      checks += 2;
      if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_full_count: got %0d, required 4", fifo_count); end
      if (in_ready !== 1'b0)   begin errors++; $display("FAIL b2b_in_ready: got %b, required 0", in_ready); end
      push(mk(CT_PT_ADD, 9, 9, 9, 9, 9, 9), 0);
      checks++;
      if (fifo_count !== 3'd4) begin errors++; $display("FAIL b2b_overflow: got %0d, required 4", fifo_count); end
      auto_done = 1; done_delay = 2;
      manual_done(1);
      wait_idle(200);
      checks += 2;
      if (ops_issued !== CW'(exp_issued)) begin
         errors++; $display("FAIL b2b_issued: got %0d, required %0d", ops_issued, exp_issued);
      end
      if (ops_completed !== CW'(exp_completed)) begin
         errors++; $display("FAIL b2b_completed: got %0d, required %0d", ops_completed, exp_completed);
      end
   endtask

   task automatic test_noop_filter();
      auto_done = 1; done_delay = 1;
      push(mk(NO_OP, 1, 1, 1, 1, 1, 1), 1);
      checks += 2;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL noop_count: got %0d, required 0", fifo_count); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL noop_busy: got %b, required 0", busy); end
      push(mk(CT_PT_MUL, 6, 7, 8, 9, 1, 2), 1);
      wait_idle(50);
      checks++;
      if (ops_issued !== CW'(exp_issued)) begin
         errors++; $display("FAIL noop_issued: got %0d, required %0d", ops_issued, exp_issued);
      end
   endtask

   task automatic test_timeout();
      int i0, comp0;
      auto_done = 0;
      push(mk(CT_CT_ADD, 8, 7, 6, 5, 4, 3), 1);
      wait_issue(10);
      i0 = last_issue_cyc;
      push(mk(CT_PT_ADD, 1, 3, 5, 7, 9, 11), 1);
      while (cyc < i0 + TMO) tick();
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b at cycle %0d, required 0", err_timeout, cyc); end
      tick();
      checks += 3;
      if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_rise: got %b at cycle %0d, required 1", err_timeout, cyc); end
      if (fifo_count !== 3'd1)  begin errors++; $display("FAIL tmo_held: got %0d, required 1", fifo_count); end
      if (busy !== 1'b1)        begin errors++; $display("FAIL tmo_busy: got %b, required 1", busy); end
      push(mk(CT_CT_MUL, 2, 4, 6, 8, 10, 12), 1);
      checks++;
      if (fifo_count !== 3'd2) begin errors++; $display("FAIL tmo_accept: got %0d, required 2", fifo_count); end
      comp0 = exp_completed;
      manual_done(0);
      tick();
      checks += 2;
      if (ops_completed !== CW'(comp0)) begin errors++; $display("FAIL tmo_late_done: got %0d, required %0d", ops_completed, comp0); end
      if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b, required 1", err_timeout); end
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b, required 0", err_timeout); end
      auto_done = 1; done_delay = 1;
      wait_idle(50);
      checks++;
      if (ops_issued !== CW'(exp_issued)) begin
         errors++; $display("FAIL tmo_issued: got %0d, required %0d", ops_issued, exp_issued);
      end
   endtask

   task automatic test_flush();
      auto_done = 0;
      push(mk(CT_CT_ADD, 1, 1, 2, 2, 3, 3), 1);
      push(mk(CT_PT_ADD, 4, 4, 5, 5, 6, 6), 1);
      push(mk(CT_CT_MUL, 7, 7, 8, 8, 9, 9), 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      checks += 2;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d, required 0", fifo_count); end
      if (busy !== 1'b1)       begin errors++; $display("FAIL flush_inflight: got %b, required 1", busy); end
      manual_done(1);
      wait_idle(50);
      repeat (5) tick();
      checks++;
      if (ops_completed !== CW'(exp_completed)) begin
         errors++; $display("FAIL flush_completed: got %0d, required %0d", ops_completed, exp_completed);
      end
      in_valid = 1'b1; in_op = mk(CT_PT_MUL, 3, 3, 3, 3, 3, 3); flush = 1'b1;
      tick();
      in_valid = 1'b0; in_op = '0; flush = 1'b0;
      checks++;
      if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_push_count: got %0d, required 0", fifo_count); end
      repeat (4) tick();
      checks++;
      if (ops_issued !== CW'(exp_issued)) begin
         errors++; $display("FAIL flush_issued: got %0d, required %0d", ops_issued, exp_issued);
      end
   endtask

   task automatic test_reset_mid_wait();
      auto_done = 0;
      push(mk(CT_CT_MUL, 2, 2, 2, 2, 2, 2), 1);
      push(mk(CT_PT_ADD, 3, 3, 3, 3, 3, 3), 1);
      push(mk(CT_CT_ADD, 4, 4, 4, 4, 4, 4), 1);
      tick();
      #2 reset = 1'b1;
      #1;
      checks += 5;
      if (cpu_op.mode !== NO_OP) begin errors++; $display("FAIL mid_rst_op: got %0d, required NO_OP", cpu_op.mode); end
      if (fifo_count !== 3'd0)   begin errors++; $display("FAIL mid_rst_count: got %0d, required 0", fifo_count); end
      if (busy !== 1'b0)         begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
      if (ops_issued !== '0)     begin errors++; $display("FAIL mid_rst_issued: got %0d, required 0", ops_issued); end
      if (ops_completed !== '0)  begin errors++; $display("FAIL mid_rst_completed: got %0d, required 0", ops_completed); end
      sb.delete(); pend = 0; prev_issue = 0; exp_issued = 0; exp_completed = 0;
      tick();
      reset = 1'b0;
      auto_done = 1; done_delay = 2;
      push(mk(CT_PT_MUL, 5, 6, 7, 8, 9, 10), 1);
      wait_idle(50);
      checks++;
      if (ops_issued !== CW'(1) || ops_completed !== CW'(1)) begin
         errors++; $display("FAIL post_rst_counts: got %0d/%0d, required 1/1", ops_issued, ops_completed);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_noop_filter();
      test_timeout();
      test_flush();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
